// File: rtl/axis_gate_sequencer.sv
// axis_gate_sequencer
// Walks a descriptor table held in an external BRAM and offers each entry on an
// AXI-Stream master port. Runs a programmable number of passes over the table
// (or runs endlessly) and stops cleanly when cfg_start is lowered.
// The BRAM address is driven from the next-state address, so it changes in the
// cycle that decides the next entry. With the 2-cycle read latency, this gives
// one descriptor every 3 cycles.
module axis_gate_sequencer #(
   parameter int BRAM_ADDR_WIDTH = 10,
   parameter int BRAM_DATA_WIDTH = 128
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic                       cfg_start,
   input  logic [BRAM_ADDR_WIDTH-1:0] cfg_last,
   input  logic [15:0]                cfg_loops,
   output logic [BRAM_ADDR_WIDTH-1:0] sts_addr,
   output logic                       sts_busy,
   output logic                       bram_porta_clk,
   output logic                       bram_porta_rst,
   output logic [BRAM_ADDR_WIDTH-1:0] bram_porta_addr,
   input  logic [BRAM_DATA_WIDTH-1:0] bram_porta_rddata,
   output logic [BRAM_DATA_WIDTH-1:0] m_axis_tdata,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t                       state_q, state_d;
   logic                         start_q;
   logic                         armed_q;
   logic [BRAM_ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [BRAM_ADDR_WIDTH-1:0]   last_q, last_d;
   logic [15:0]                  pass_q, pass_d;
   logic [15:0]                  loops_q, loops_d;
   logic                         fcnt_q, fcnt_d;
   logic [BRAM_DATA_WIDTH-1:0]   tdata_q, tdata_d;

   logic                         start_rise;
   logic [15:0]                  pass_inc;

   // armed_q suppresses a spurious edge when cfg_start is already high at reset release
   assign start_rise = cfg_start & ~start_q & armed_q;
   assign pass_inc   = pass_q + 16'd1;

   // State and datapath registers; reset forces the idle, empty-output condition
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= IDLE;
         start_q <= 1'b0;
         armed_q <= 1'b0;
         addr_q  <= '0;
         last_q  <= '0;
         pass_q  <= '0;
         loops_q <= '0;
         fcnt_q  <= 1'b0;
         tdata_q <= '0;
      end else begin
         state_q <= state_d;
         start_q <= cfg_start;
         armed_q <= 1'b1;
         addr_q  <= addr_d;
         last_q  <= last_d;
         pass_q  <= pass_d;
         loops_q <= loops_d;
         fcnt_q  <= fcnt_d;
         tdata_q <= tdata_d;
      end
   end

   // Next-state logic: start capture, fetch wait, handshake bookkeeping and stop handling
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      last_d  = last_q;
      pass_d  = pass_q;
      loops_d = loops_q;
      fcnt_d  = fcnt_q;
      tdata_d = tdata_q;
      case (state_q)
         IDLE: begin
            if (start_rise) begin
               last_d  = cfg_last;
               loops_d = cfg_loops;
               addr_d  = '0;
               pass_d  = '0;
               fcnt_d  = 1'b0;
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (!cfg_start) begin
               // Abandon the read; nothing has been offered for this entry yet
               fcnt_d  = 1'b0;
               state_d = DRAIN;
            end else if (fcnt_q) begin
               tdata_d = bram_porta_rddata;
               fcnt_d  = 1'b0;
               state_d = SEND;
            end else begin
               fcnt_d  = 1'b1;
            end
         end
         SEND: begin
            // tvalid stays up regardless of cfg_start until the word is taken
            if (m_axis_tready) begin
               fcnt_d  = 1'b0;
               state_d = FETCH;
               if (addr_q == last_q) begin
                  addr_d = '0;
                  pass_d = pass_inc;
                  if ((loops_q != 16'd0) && (pass_inc == loops_q)) begin
                     state_d = IDLE;
                  end
               end else begin
                  addr_d = addr_q + BRAM_ADDR_WIDTH'(1);
               end
               if (!cfg_start) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bram_porta_clk  = aclk;
   assign bram_porta_rst  = ~aresetn;
   assign bram_porta_addr = addr_d;
   assign sts_addr        = addr_q;
   assign sts_busy        = (state_q != IDLE);
   assign m_axis_tvalid   = (state_q == SEND);
   assign m_axis_tdata    = tdata_q;

endmodule
